// File: rtl/i2s_adc_capture.sv
// I2S ADC capture: synchronizes the codec serial stream into clk and deserializes
// DATA_W-bit samples onto a valid/ready port. Define STEREO_EN to capture both channels.
module i2s_adc_capture #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_done,
    input  logic              rec_en,
    input  logic              aud_bclk,
    input  logic              aud_adclrck,
    input  logic              aud_adcdat,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              sample_chan,
    output logic              overflow,
    output logic              busy
);
    // state     | meaning
    // IDLE      | waiting for init_done and rec_en
    // ALIGN     | waiting for the first word-start LRCK edge
    // SHIFT     | shifting data bits of the current word
    // WAIT_EDGE | word done, ignoring bits until the next word start

    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, WAIT_EDGE} state_t;

    state_t            state;
    logic [SYNC_N-1:0] bclk_sync;
    logic [SYNC_N-1:0] lrck_sync;
    logic [SYNC_N-1:0] dat_sync;
    logic              bclk_prev;
    logic              lrck_prev;
    logic              rec_en_prev;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              cur_chan;

    logic              bclk_s;
    logic              lrck_s;
    logic              dat_s;
    logic              bclk_rise;
    logic              lrck_edge;
    logic              word_start;
    logic              start_chan;
    logic              enabled;
    logic              last_bit;
    logic              word_done;
    logic [DATA_W-1:0] word;

    assign bclk_s    = bclk_sync[SYNC_N-1];
    assign lrck_s    = lrck_sync[SYNC_N-1];
    assign dat_s     = dat_sync[SYNC_N-1];
    assign bclk_rise = bclk_s & ~bclk_prev;
    assign lrck_edge = bclk_rise & (lrck_s ^ lrck_prev);
    assign enabled   = init_done & rec_en;
    assign last_bit  = (bit_cnt == CNT_W'(DATA_W - 1));
    assign word_done = enabled & (state == SHIFT) & bclk_rise & last_bit;
    assign word      = {shift[DATA_W-2:0], dat_s};

`ifdef STEREO_EN
    assign word_start = lrck_edge;
    assign start_chan = lrck_s;
`else
    assign word_start = lrck_edge & ~lrck_s;
    assign start_chan = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_N-2:0], aud_bclk};
            lrck_sync <= {lrck_sync[SYNC_N-2:0], aud_adclrck};
            dat_sync  <= {dat_sync[SYNC_N-2:0], aud_adcdat};
            bclk_prev <= bclk_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            cur_chan  <= 1'b0;
            lrck_prev <= 1'b0;
        end else begin
            if (bclk_rise)
                lrck_prev <= lrck_s;
            if (!enabled) begin
                state   <= IDLE;
                busy    <= 1'b0;
                bit_cnt <= '0;
                shift   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ALIGN;
                        busy  <= 1'b1;
                    end
                    ALIGN: begin
                        // The start edge is the I2S delay slot; no data on it.
                        if (word_start) begin
                            bit_cnt  <= '0;
                            shift    <= '0;
                            cur_chan <= start_chan;
                            state    <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (bclk_rise) begin
                            if (last_bit) begin
                                // Completion wins over a coincident LRCK edge (16-bit slots).
                                bit_cnt <= '0;
                                shift   <= word;
                                if (word_start)
                                    cur_chan <= start_chan;
                                else
                                    state <= WAIT_EDGE;
                            end else if (lrck_edge) begin
                                bit_cnt <= '0;
                                shift   <= '0;
                                if (word_start)
                                    cur_chan <= start_chan;
                                else
                                    state <= WAIT_EDGE;
                            end else begin
                                shift   <= word;
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    WAIT_EDGE: begin
                        if (word_start) begin
                            bit_cnt  <= '0;
                            shift    <= '0;
                            cur_chan <= start_chan;
                            state    <= SHIFT;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_data  <= '0;
            sample_valid <= 1'b0;
            sample_chan  <= 1'b0;
            overflow     <= 1'b0;
            rec_en_prev  <= 1'b0;
        end else begin
            rec_en_prev <= rec_en;
            if (word_done) begin
                if (!sample_valid || sample_ready) begin
                    sample_data  <= word;
                    sample_chan  <= cur_chan;
                    sample_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (rec_en_prev && !rec_en)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_adc_capture.sv
// Scoreboard bench for i2s_adc_capture: a word-level I2S stream model pushes expected
// samples; a monitor pops and compares on every accepted handshake.
`timescale 1ns/1ps
module tb_i2s_adc_capture;
`ifdef STEREO_EN
    localparam bit STEREO = 1'b1;
`else
    localparam bit STEREO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_done = 1'b0;
    logic        rec_en = 1'b0;
    logic        aud_bclk = 1'b0;
    logic        aud_adclrck = 1'b1;
    logic        aud_adcdat = 1'b0;
    logic        sample_ready = 1'b0;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_chan;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int valid_cycles = 0;
    logic [16:0] exp_q[$];
    bit q_lr[$];
    bit q_da[$];
    bit spill_pend = 1'b0;
    bit spill_bit = 1'b0;
    int hit_idx = -1;
    int rst_idx = -1;
    bit stream_active = 1'b0;

    always #5 clk = ~clk;

    i2s_adc_capture #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .init_done(init_done), .rec_en(rec_en),
        .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_chan(sample_chan), .overflow(overflow), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One LRCK half of h bit clocks; the word starts one bit after the edge, MSB first.
    // A word fits when its 16 bits land before or on the next edge's first bit clock.
    function automatic void add_half(input bit lr, input int h, input logic [15:0] w, input bit exp_ok);
        int start;
        start = q_lr.size();
        for (int i = 0; i < h; i++) begin
            q_lr.push_back(lr);
            q_da.push_back(1'($urandom));
        end
        if (spill_pend) begin
            q_da[start] = spill_bit;
            spill_pend = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            int idx;
            idx = start + 1 + i;
            if (idx < q_lr.size())
                q_da[idx] = w[15-i];
            else if (idx == q_lr.size()) begin
                spill_pend = 1'b1;
                spill_bit = w[15-i];
            end
        end
        if (exp_ok && h >= 16 && (lr == 1'b0 || STEREO))
            exp_q.push_back({lr, w});
    endfunction

    task automatic play();
        for (int i = 0; i < q_lr.size(); i++) begin
            @(negedge clk);
            aud_bclk = 1'b0;
            aud_adclrck = q_lr[i];
            aud_adcdat = q_da[i];
            repeat (4) @(negedge clk);
            aud_bclk = 1'b1;
            if (i == hit_idx) begin
                // Ready held only for the cycle the synchronized rise is acted on.
                repeat (2) @(posedge clk);
                #1 sample_ready = 1'b1;
                @(posedge clk);
                #1 sample_ready = 1'b0;
            end
            if (i == rst_idx) begin
                repeat (2) @(posedge clk);
                #1 check("busy_in_shift", 32'(busy), 32'd1);
                reset = 1'b0;
                #1;
                check("rst_sample_data", 32'(sample_data), 32'd0);
                check("rst_sample_valid", 32'(sample_valid), 32'd0);
                check("rst_sample_chan", 32'(sample_chan), 32'd0);
                check("rst_overflow", 32'(overflow), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                @(negedge clk);
                reset = 1'b1;
            end
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        aud_bclk = 1'b0;
        q_lr.delete();
        q_da.delete();
        hit_idx = -1;
        rst_idx = -1;
        spill_pend = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (20) @(negedge clk);
    endtask

    task automatic start_test();
        reset = 1'b0;
        sample_ready = 1'b0;
        rec_en = 1'b0;
        init_done = 1'b0;
        aud_bclk = 1'b0;
        aud_adclrck = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        init_done = 1'b1;
        rec_en = 1'b1;
        valid_cycles = 0;
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset && sample_valid)
            valid_cycles++;
        if (reset && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample actual=%0h required=none", sample_data);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("sample_data", 32'(sample_data), 32'(e[15:0]));
                check("sample_chan", 32'(sample_chan), 32'(e[16]));
            end
        end
    end

    initial begin
        int s;
        bit lr;
        int h;

        // Reset values
        repeat (2) @(negedge clk);
        check("init_sample_data", 32'(sample_data), 32'd0);
        check("init_sample_valid", 32'(sample_valid), 32'd0);
        check("init_overflow", 32'(overflow), 32'd0);
        check("init_busy", 32'(busy), 32'd0);

        // Reset mid-word after 5 data bits; only a word after a fresh edge may appear
        start_test();
        sample_ready = 1'b1;
        add_half(1'b1, 4, 16'h0, 1'b0);
        s = q_lr.size();
        add_half(1'b0, 18, 16'hC3C3, 1'b0);
        rst_idx = s + 6;
        add_half(1'b1, 18, 16'h6A6A, 1'b1);
        add_half(1'b0, 18, 16'h2B4D, 1'b1);
        add_half(1'b1, 18, 16'h1E1E, 1'b1);
        add_half(1'b0, 4, 16'h0, 1'b0);
        play();
        drain();

`ifndef STEREO_EN
        // Basic left capture, one-clk valid pulse, right word ignored
        start_test();
        sample_ready = 1'b1;
        add_half(1'b1, 4, 16'h0, 1'b0);
        add_half(1'b0, 18, 16'hA5C3, 1'b1);
        add_half(1'b1, 18, 16'hFFFF, 1'b1);
        add_half(1'b0, 4, 16'h0, 1'b0);
        play();
        drain();
        check("valid_pulse_width", 32'(valid_cycles), 32'd1);

        // Overflow: second word dropped, rec_en fall clears overflow, held word still delivered
        start_test();
        add_half(1'b1, 4, 16'h0, 1'b0);
        add_half(1'b0, 18, 16'h1234, 1'b1);
        add_half(1'b1, 18, 16'hAAAA, 1'b0);
        add_half(1'b0, 18, 16'h5678, 1'b0);
        add_half(1'b1, 18, 16'h5555, 1'b0);
        add_half(1'b0, 4, 16'h0, 1'b0);
        play();
        repeat (10) @(negedge clk);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_data_held", 32'(sample_data), 32'h1234);
        rec_en = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(overflow), 32'd0);
        sample_ready = 1'b1;
        drain();

        // Ready in the completion cycle: old accepted, new loaded, no overflow
        start_test();
        add_half(1'b1, 4, 16'h0, 1'b0);
        add_half(1'b0, 18, 16'h8001, 1'b1);
        add_half(1'b1, 18, 16'h3C3C, 1'b1);
        s = q_lr.size();
        add_half(1'b0, 18, 16'h0F0F, 1'b1);
        hit_idx = s + 16;
        add_half(1'b1, 18, 16'h4242, 1'b1);
        add_half(1'b0, 4, 16'h0, 1'b0);
        play();
        repeat (5) @(negedge clk);
        check("same_cycle_no_ovf", 32'(overflow), 32'd0);
        sample_ready = 1'b1;
        drain();

        // Short left frame (9 bits) discarded, next full word captured
        start_test();
        sample_ready = 1'b1;
        add_half(1'b1, 4, 16'h0, 1'b0);
        add_half(1'b0, 10, 16'hDEAD, 1'b1);
        add_half(1'b1, 18, 16'hBEEF, 1'b1);
        add_half(1'b0, 18, 16'h7FFE, 1'b1);
        add_half(1'b1, 18, 16'h0101, 1'b1);
        add_half(1'b0, 4, 16'h0, 1'b0);
        play();
        drain();
        check("short_no_ovf", 32'(overflow), 32'd0);
`else
        // Stereo: left then right, channel tags 0 then 1
        start_test();
        sample_ready = 1'b1;
        add_half(1'b1, 4, 16'h0, 1'b0);
        add_half(1'b0, 18, 16'h0001, 1'b1);
        add_half(1'b1, 18, 16'h8000, 1'b1);
        add_half(1'b0, 4, 16'h0, 1'b0);
        play();
        drain();
`endif

        // Randomized frames, occasional short halves, random ready
        start_test();
        add_half(1'b1, 4, 16'h0, 1'b0);
        lr = 1'b0;
        for (int k = 0; k < 16; k++) begin
            h = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 15)) : int'($urandom_range(16, 20));
            add_half(lr, h, 16'($urandom), 1'b1);
            lr = ~lr;
        end
        add_half(lr, 4, 16'h0, 1'b0);
        stream_active = 1'b1;
        fork
            begin
                play();
                stream_active = 1'b0;
            end
            begin
                while (stream_active) begin
                    @(negedge clk);
                    sample_ready = 1'($urandom);
                end
            end
        join
        sample_ready = 1'b1;
        drain();
        check("random_no_ovf", 32'(overflow), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_adc_capture.md
Name: i2s_adc_capture

Overview:
- Sits directly downstream of the codec I2C initializer. The codec is configured as I2S master, 16-bit word length.
- Once the initializer's done is seen, the block receives the codec's ADC serial stream (BCLK, ADCLRCK, ADCDAT) in the system clk domain.
- It deserializes left-channel samples and hands them to the recorder/SRAM writer over a valid/ready interface.

Parameters:
- DATA_W, 16, sample word width; must match the codec IWL setting.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 4x the BCLK frequency.
- reset  input  1  asynchronous, active-low reset.
- init_done  input  1  codec configuration complete (initializer done); level.
- rec_en  input  1  recording enable; level.
- aud_bclk  input  1  codec bit clock; asynchronous to clk.
- aud_adclrck  input  1  codec ADC LR clock; low = left, high = right.
- aud_adcdat  input  1  codec ADC serial data, MSB first.
- sample_data  output  DATA_W  captured sample, two's complement.
- sample_valid  output  1  sample_data holds an undelivered sample.
- sample_ready  input  1  downstream accepts the sample when high together with sample_valid.
- sample_chan  output  1  channel tag of sample_data (0 = left).
- overflow  output  1  sticky; at least one sample was dropped.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: sample_data=0, sample_valid=0, sample_chan=0, overflow=0, busy=0, state=IDLE, bit_cnt=0, shift register=0.
- Synchronization:
  - aud_bclk, aud_adclrck and aud_adcdat each pass through SYNC_STAGES flops.
  - bclk_rise is a one-clk pulse, generated when the previous synchronized bclk is 0 and the current one is 1.
  - All capture logic acts only in cycles where bclk_rise=1.
  - lrck_prev is updated on every bclk_rise.
- States:
  - IDLE:
    - Wait for init_done=1 and rec_en=1, then go to ALIGN.
  - ALIGN:
    - On a bclk_rise where lrck_prev=1 and the current LRCK=0 (start of the left channel): bit_cnt=0, go to SHIFT.
    - That rise is the I2S one-bit delay slot; no data is sampled on it.
  - SHIFT:
    - Each bclk_rise: shift = {shift[DATA_W-2:0], adcdat}; bit_cnt increments.
    - On the rise that captures bit DATA_W-1: present the word (see Output register) and go to WAIT_EDGE.
  - WAIT_EDGE:
    - Ignore data bits.
    - On the next LRCK 1->0 transition seen at a bclk_rise: bit_cnt=0, go to SHIFT.
- LRCK edge during SHIFT (short frame): discard the partial word, bit_cnt=0.
  - If the new level is 0, stay in SHIFT.
  - If the new level is 1, go to WAIT_EDGE.
- Abort: rec_en=0 or init_done=0 in any state → IDLE on the next clk, and the partial word is discarded.
  - A pending output sample remains valid until accepted.
  - overflow clears on the clk where rec_en transitions 1->0.
- Output register:
  - When a word completes and sample_valid=0: load sample_data, set sample_valid=1 on the next clk. Latency is 1 clk after the bclk_rise carrying the LSB.
  - sample_valid&&sample_ready: sample_valid falls on the next clk, unless a word completes in that same cycle. In that case the new word loads and sample_valid stays 1.
  - Word completes while sample_valid=1 and sample_ready=0: the new word is dropped, the old one is kept unchanged, and overflow=1.
  - sample_data and sample_chan hold stable while sample_valid=1 and sample_ready=0.
- Arithmetic: bit_cnt is $clog2(DATA_W)+1 bits wide and never wraps within a word.

Optional Feature:
- Macro STEREO_EN.
- Defined:
  - ALIGN/WAIT_EDGE accept both LRCK edges as word starts.
  - The right word (LRCK=1) is captured as well.
  - sample_chan = LRCK level at word start.
  - Left and right samples alternate on the interface, with the same overflow rules per word.
- Undefined:
  - Only the left channel is captured.
  - sample_chan is tied to 0.

Test Plan:
- Reset mid-SHIFT, with 5 bits captured: assert reset=0 → all outputs 0 and state IDLE immediately. After release, with init_done=1 and rec_en=1, no sample appears until a fresh LRCK 1->0 edge.
- init_done=1, rec_en=1, BCLK=clk/8, left word 16'hA5C3 sent I2S-aligned, ready=1 → sample_data=16'hA5C3 and sample_valid pulses 1 clk, 1 clk after the LSB rise. Right word 16'hFFFF is ignored.
- ready=0 while two left words 16'h1234 then 16'h5678 arrive → sample_data stays 16'h1234, overflow=1. Dropping rec_en then clears overflow, and 16'h1234 is still delivered on ready=1.
- ready asserted in the same cycle as the completion of word 16'h0F0F following 16'h8001 → 16'h8001 is accepted, 16'h0F0F loads, and sample_valid stays 1 with no overflow.
- LRCK toggles after 9 bits of a left word → the partial word is discarded with no valid. The next full word 16'h7FFE is captured correctly.
- STEREO_EN defined, L=16'h0001 and R=16'h8000 → two samples in order, sample_chan 0 then 1.
